// File: rtl/board_attack_checker.sv
// board_attack_checker
// Per-player board responder for the Battleship game controller. Holds one
// player's ship map and the committed attack map fired against it. An attack
// request captures the opponent's switch pattern and scans it one cell per
// cycle. The pattern is legal only if it adds exactly one new shot and
// removes none. A legal attack is committed and reported as a hit or a miss.
//
// Ports:
//   clk        system clock
//   clr        asynchronous active-high reset
//   sw         owning player's switches, taken as the ship map on ld_ship
//   atk_in     opponent's attack switches, captured on ld_atk
//   ld_ship    1-cycle strobe: load ship map and start a new game
//   ld_atk     1-cycle strobe: start validating an attack
//   busy       high while a validation is in progress (SCAN and DECIDE)
//   done       1-cycle pulse in the DECIDE cycle
//   ok         last attack was legal
//   hit        last legal attack landed on a ship cell
//   alive      ships_left != 0
//   ships_left un-hit ship cells remaining
//   shots      number of committed attack cells
module board_attack_checker #(
    parameter int CELLS = 16,
    parameter int CW    = $clog2(CELLS + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [CELLS-1:0] sw,
    input  logic [CELLS-1:0] atk_in,
    input  logic             ld_ship,
    input  logic             ld_atk,
    output logic             busy,
    output logic             done,
    output logic             ok,
    output logic             hit,
    output logic             alive,
    output logic [CW-1:0]    ships_left,
    output logic [CW-1:0]    shots
);

    localparam int IW = $clog2(CELLS);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DECIDE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CELLS-1:0] ship_reg;
    logic [CELLS-1:0] atk_reg;
    logic [CELLS-1:0] cap_reg;
    logic [IW-1:0]    idx;
    logic [1:0]       new_cnt;
    logic             removed;
    logic [IW-1:0]    new_idx;

    logic             last_cell;
    logic             legal;
    logic             hit_now;

    function automatic logic [CW-1:0] popcount(input logic [CELLS-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < CELLS; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    assign last_cell = (idx == IW'(CELLS - 1));
    assign legal     = (new_cnt == 2'd1) && !removed;
    assign hit_now   = ship_reg[new_idx];

    assign busy  = (state != IDLE);
    assign done  = (state == DECIDE);
    assign alive = (ships_left != '0);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A simultaneous ld_ship takes priority, so the attack strobe is dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ld_atk && !ld_ship) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (last_cell) begin
                    state_nxt = DECIDE;
                end
            end
            DECIDE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ship_reg   <= '0;
            atk_reg    <= '0;
            cap_reg    <= '0;
            idx        <= '0;
            new_cnt    <= '0;
            removed    <= 1'b0;
            new_idx    <= '0;
            ok         <= 1'b0;
            hit        <= 1'b0;
            ships_left <= '0;
            shots      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_ship) begin
                        ship_reg   <= sw;
                        atk_reg    <= '0;
                        ships_left <= popcount(sw);
                        shots      <= '0;
                        ok         <= 1'b0;
                        hit        <= 1'b0;
                    end else if (ld_atk) begin
                        cap_reg <= atk_in;
                        idx     <= '0;
                        new_cnt <= '0;
                        removed <= 1'b0;
                    end
                end
                SCAN: begin
                    // The new-cell count saturates at 2: any count above one is illegal.
                    if (cap_reg[idx] && !atk_reg[idx]) begin
                        if (new_cnt != 2'd2) begin
                            new_cnt <= new_cnt + 2'd1;
                        end
                        if (new_cnt == 2'd0) begin
                            new_idx <= idx;
                        end
                    end
                    if (atk_reg[idx] && !cap_reg[idx]) begin
                        removed <= 1'b1;
                    end
                    idx <= idx + IW'(1);
                end
                DECIDE: begin
                    ok <= legal;
                    // A legal shot is always on a cell not previously attacked,
                    // so a hit cannot take ships_left below zero.
                    if (legal) begin
                        atk_reg <= cap_reg;
                        shots   <= shots + CW'(1);
                        hit     <= hit_now;
                        if (hit_now) begin
                            ships_left <= ships_left - CW'(1);
                        end
                    end else begin
                        hit <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_attack_checker.sv
module tb_board_attack_checker;

    localparam int CELLS = 16;
    localparam int CW    = $clog2(CELLS + 1);

    logic             clk = 1'b0;
    logic             clr;
    logic [CELLS-1:0] sw;
    logic [CELLS-1:0] atk_in;
    logic             ld_ship;
    logic             ld_atk;
    logic             busy;
    logic             done;
    logic             ok;
    logic             hit;
    logic             alive;
    logic [CW-1:0]    ships_left;
    logic [CW-1:0]    shots;

    int tests = 0;
    int fails = 0;

    board_attack_checker #(.CELLS(CELLS)) dut (
        .clk        (clk),
        .clr        (clr),
        .sw         (sw),
        .atk_in     (atk_in),
        .ld_ship    (ld_ship),
        .ld_atk     (ld_atk),
        .busy       (busy),
        .done       (done),
        .ok         (ok),
        .hit        (hit),
        .alive      (alive),
        .ships_left (ships_left),
        .shots      (shots)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one strobe cycle; returns at the falling edge after the sampling edge.
    task automatic applyStimulus(input logic [CELLS-1:0] s, input logic [CELLS-1:0] a,
                                 input logic ls, input logic la);
        @(negedge clk);
        sw      = s;
        atk_in  = a;
        ld_ship = ls;
        ld_atk  = la;
        @(negedge clk);
        ld_ship = 1'b0;
        ld_atk  = 1'b0;
    endtask

    // Idle-state board outputs.
    task automatic checkBoard(input string tag, input logic eok, input logic ehit,
                              input int eships, input int eshots);
        checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
        checkOutput({tag, ".ok"}, 32'(ok), 32'(eok));
        checkOutput({tag, ".hit"}, 32'(hit), 32'(ehit));
        checkOutput({tag, ".ships_left"}, 32'(ships_left), 32'(eships));
        checkOutput({tag, ".shots"}, 32'(shots), 32'(eshots));
        checkOutput({tag, ".alive"}, 32'(alive), (eships != 0) ? 32'd1 : 32'd0);
    endtask

    // Starts an attack, measures the done latency, then checks the committed result.
    // With inject set, a second ld_atk is pulsed in the middle of the scan.
    task automatic runAttack(input string tag, input logic [CELLS-1:0] a, input logic inject,
                             input logic eok, input logic ehit, input int eships, input int eshots);
        int cyc;
        applyStimulus(sw, a, 1'b0, 1'b1);
        cyc = 1;
        checkOutput({tag, ".busy_start"}, 32'(busy), 32'd1);
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (inject && cyc == 5) begin
                ld_atk = 1'b1;
                atk_in = 16'h0030;
            end else begin
                ld_atk = 1'b0;
            end
        end
        checkOutput({tag, ".done_cycle"}, 32'(cyc), 32'd17);
        checkOutput({tag, ".busy_at_done"}, 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput({tag, ".done_width"}, 32'(done), 32'd0);
        checkBoard(tag, eok, ehit, eships, eshots);
    endtask

    // Confirms nothing starts or completes over n cycles.
    task automatic checkQuiet(input string tag, input int n);
        int dones;
        int busys;
        dones = 0;
        busys = 0;
        repeat (n) begin
            @(negedge clk);
            if (done) dones++;
            if (busy) busys++;
        end
        checkOutput({tag, ".no_done"}, 32'(dones), 32'd0);
        checkOutput({tag, ".no_busy"}, 32'(busys), 32'd0);
    endtask

    initial begin
        clr     = 1'b1;
        sw      = '0;
        atk_in  = '0;
        ld_ship = 1'b0;
        ld_atk  = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset.done", 32'(done), 32'd0);
        checkBoard("reset", 1'b0, 1'b0, 0, 0);
        clr = 1'b0;

        applyStimulus(16'h0003, 16'h0000, 1'b1, 1'b0);
        checkBoard("load", 1'b0, 1'b0, 2, 0);

        runAttack("atk1", 16'h0001, 1'b0, 1'b1, 1'b1, 1, 1);
        runAttack("atk2_miss", 16'h0011, 1'b0, 1'b1, 1'b0, 1, 2);
        runAttack("atk3_two_new", 16'h1111, 1'b0, 1'b0, 1'b0, 1, 2);
        runAttack("atk4_removed", 16'h0010, 1'b0, 1'b0, 1'b0, 1, 2);
        runAttack("atk5_sink", 16'h0013, 1'b0, 1'b1, 1'b1, 0, 3);
        runAttack("atk6_repeat", 16'h0013, 1'b0, 1'b0, 1'b0, 0, 3);

        applyStimulus(16'h00F0, 16'h0001, 1'b1, 1'b1);
        checkBoard("both_strobes", 1'b0, 1'b0, 4, 0);
        checkQuiet("both_strobes", 20);

        runAttack("atk_busy_inject", 16'h0010, 1'b1, 1'b1, 1'b1, 3, 1);
        checkQuiet("busy_inject", 25);

        applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b0);
        checkBoard("zero_ships", 1'b0, 1'b0, 0, 0);

        applyStimulus(16'h0003, 16'h0000, 1'b1, 1'b0);
        applyStimulus(16'h0003, 16'h0001, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        checkOutput("mid_scan.busy_before", 32'(busy), 32'd1);
        clr = 1'b1;
        #1;
        checkOutput("mid_scan.done", 32'(done), 32'd0);
        checkBoard("mid_scan_clr", 1'b0, 1'b0, 0, 0);
        @(negedge clk);
        clr = 1'b0;
        checkQuiet("mid_scan", 25);
        checkBoard("mid_scan_after", 1'b0, 1'b0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/board_attack_checker.md
Name: board_attack_checker

Overview:
Per-player board responder for the Battleship game controller. It holds one player's ship map and the committed attack map fired against that board. On an attack request it serially scans the board to validate the opponent's new switch pattern, which must add exactly one new shot and remove none. It then reports ok/hit, updates the remaining-ship count and drives alive. The game FSM issues ld_ship/ld_atk strobes and consumes done/ok/alive.

Parameters:
CELLS, 16, number of board cells (one switch per cell); must be >= 2
CW, $clog2(CELLS+1), width of ship/shot counters

Ports:
clk  input  1  system clock
clr  input  1  reset, asynchronous, active-high
sw  input  CELLS  owning player's switches, sampled on ld_ship as ship map
atk_in  input  CELLS  opponent's attack switches, sampled on ld_atk
ld_ship  input  1  load ship map / new game on this board (1-cycle strobe)
ld_atk  input  1  start attack validation (1-cycle strobe)
busy  output  1  high while validation scan in progress
done  output  1  1-cycle pulse: ok/hit valid and committed
ok  output  1  last attack legal (exactly one new cell, none removed)
hit  output  1  last legal attack landed on a ship cell
alive  output  1  ships_left != 0
ships_left  output  CW  un-hit ship cells remaining
shots  output  CW  number of committed attack cells

Behaviour:
- Reset (clr=1, async): state IDLE; ship_reg, atk_reg, cap_reg, idx, new_cnt, removed, new_idx cleared; busy=0, done=0, ok=0, hit=0, alive=0, ships_left=0, shots=0.
- States: IDLE, SCAN, DECIDE.
- IDLE:
  - ld_ship=1 → ship_reg<=sw; atk_reg<=0; ships_left<=popcount(sw); shots<=0; ok<=0; hit<=0; stay IDLE.
  - ld_atk=1 with ld_ship=0 → cap_reg<=atk_in; idx<=0; new_cnt<=0; removed<=0; go SCAN.
  - ld_ship and ld_atk in the same cycle → ld_ship wins; ld_atk is dropped.
- SCAN: busy=1; one cell per cycle, idx = 0..CELLS-1.
  - cap[idx] & ~atk[idx] → new_cnt increments, saturating at 2; new_idx<=idx on the first new cell.
  - atk[idx] & ~cap[idx] → removed<=1.
  - idx==CELLS-1 → go DECIDE.
- DECIDE: busy=1, single cycle, then IDLE.
  - legal = (new_cnt==1) && !removed.
  - ok<=legal; done=1 this cycle (registered pulse visible in the DECIDE cycle).
  - If legal: atk_reg<=cap_reg; shots<=shots+1; hit<=ship_reg[new_idx]; if hit, ships_left<=ships_left-1.
  - If illegal: atk_reg, shots, ships_left unchanged; hit<=0.
- Latency: ld_atk sampled at edge t → SCAN occupies CELLS cycles → DECIDE/done in cycle t+CELLS+1. busy is high from cycle t+1 through the DECIDE cycle.
- ld_atk and ld_ship while busy are ignored (no queueing).
- ok/hit hold their value until the next DECIDE or ld_ship.
- alive is combinational from ships_left!=0. A board loaded with zero ships reads alive=0 immediately.
- ships_left never underflows: a hit is only possible on a ship cell not previously attacked, so it cannot go below 0.
- shots is bounded by CELLS, so no saturation is needed.
- Repeat attack with an identical pattern: new_cnt=0 → ok=0.
- clr mid-SCAN: immediate return to the reset state; no done is produced.

Test Plan:
- Reset, then ld_ship with sw=16'h0003 → ships_left=2, alive=1, shots=0, ok=0, hit=0.
- ld_atk with atk_in=16'h0001 → busy 16+1 cycles; done exactly in cycle 17 after the strobe; ok=1, hit=1, ships_left=1, shots=1.
- Next ld_atk with atk_in=16'h0011 (new cell 4, no ship) → ok=1, hit=0, ships_left=1, shots=2.
- ld_atk with atk_in=16'h0111 plus 16'h1000 set (two new cells) → ok=0, atk_reg/shots/ships_left unchanged.
- ld_atk with atk_in=16'h0010 (cell 0 removed, no new cell) → ok=0. Then 16'h0013 → ok=1, hit=1, ships_left=0, alive=0.
- Boundary cases:
  - Same-cycle ld_ship+ld_atk in IDLE → ship load only, busy stays 0.
  - ld_atk pulsed while busy → ignored, single done.
  - clr asserted mid-SCAN → all outputs 0 next edge, no done.
